// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous RAM between the instruction-fetch port
// (read-only) and the load/store data port (read/write). Grants are combinational, the
// read return is tracked by a registered owner, and a starvation counter forces fetch
// through after STARVE_LIMIT denied cycles.
// Optional feature: define MEM_ARB_RR_EN to replace fixed data priority on conflicts
// with round-robin between the two requesters.
module mem_arbiter #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic                clk,
    input  logic                reset,
    // instruction-fetch port
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_gnt,
    output logic                i_rvalid,
    output logic [DATA_W-1:0]   i_rdata,
    // data port
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_wstrb,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    // RAM port
    output logic                ram_en,
    output logic                ram_we,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [DATA_W-1:0]   ram_wdata,
    output logic [DATA_W/8-1:0] ram_wstrb,
    input  logic [DATA_W-1:0]   ram_rdata
);

    localparam int unsigned CNT_W  = $clog2(STARVE_LIMIT + 1);
    localparam int unsigned STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {
        OwnerNone  = 2'd0,
        OwnerInstr = 2'd1,
        OwnerData  = 2'd2
    } owner_e;

    owner_e           owner_q, owner_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             starve_hit;

    assign starve_hit = (wait_cnt_q == CNT_W'(STARVE_LIMIT));

`ifdef MEM_ARB_RR_EN
    localparam logic WinInstr = 1'b0;
    localparam logic WinData  = 1'b1;

    logic last_win_q, last_win_d;

    // Pick the winner: round-robin on conflict, lone requester otherwise.
    always_comb begin
        i_gnt = 1'b0;
        d_gnt = 1'b0;
        if (!reset) begin
            if (i_req && d_req) begin
                // starve_hit cannot fire here in practice; kept as a harmless backstop
                if (last_win_q == WinData || starve_hit) begin
                    i_gnt = 1'b1;
                end else begin
                    d_gnt = 1'b1;
                end
            end else begin
                i_gnt = i_req;
                d_gnt = d_req;
            end
        end
    end

    // Remember the conflict winner so the other side wins the next conflict.
    always_comb begin
        last_win_d = last_win_q;
        if (i_req && d_req) begin
            last_win_d = i_gnt ? WinInstr : WinData;
        end
    end

    // Round-robin history register; reset to DATA so fetch wins the first conflict.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_win_q <= WinData;
        end else begin
            last_win_q <= last_win_d;
        end
    end
`else
    // Pick the winner: data priority on conflict unless fetch has starved.
    always_comb begin
        i_gnt = 1'b0;
        d_gnt = 1'b0;
        if (!reset) begin
            if (i_req && d_req) begin
                if (starve_hit) begin
                    i_gnt = 1'b1;
                end else begin
                    d_gnt = 1'b1;
                end
            end else begin
                i_gnt = i_req;
                d_gnt = d_req;
            end
        end
    end
`endif

    // Drive the RAM from the winner; everything is zero when idle.
    always_comb begin
        ram_en    = i_gnt | d_gnt;
        ram_we    = d_gnt & d_we;
        ram_addr  = '0;
        ram_wdata = '0;
        ram_wstrb = '0;
        if (d_gnt) begin
            ram_addr  = d_addr;
            ram_wdata = d_wdata;
            ram_wstrb = d_we ? d_wstrb : {STRB_W{1'b0}};
        end else if (i_gnt) begin
            ram_addr = i_addr;
        end
    end

    // Next owner of the return slot and next starvation count.
    always_comb begin
        owner_d = OwnerNone;
        if (i_gnt) begin
            owner_d = OwnerInstr;
        end else if (d_gnt) begin
            // writes are tracked too so their completion pulse issues
            owner_d = OwnerData;
        end

        wait_cnt_d = '0;
        if (i_req && !i_gnt) begin
            wait_cnt_d = starve_hit ? wait_cnt_q : wait_cnt_q + CNT_W'(1);
        end
    end

    // Return-owner and starvation state; async reset kills any read in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_q    <= OwnerNone;
            wait_cnt_q <= '0;
        end else begin
            owner_q    <= owner_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign i_rvalid = (owner_q == OwnerInstr);
    assign d_rvalid = (owner_q == OwnerData);
    assign i_rdata  = ram_rdata;
    assign d_rdata  = ram_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter with a small byte-strobed
// synchronous RAM model behind it. Inputs change on the falling edge and outputs are
// sampled 1 time unit later, well away from the rising edge.
module tb_mem_arbiter;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_gnt;
    logic              i_rvalid;
    logic [DATA_W-1:0] i_rdata;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [3:0]        d_wstrb;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [3:0]        ram_wstrb;
    logic [DATA_W-1:0] ram_rdata;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] mem [0:255];

    mem_arbiter #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .STARVE_LIMIT(8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_gnt    (i_gnt),
        .i_rvalid (i_rvalid),
        .i_rdata  (i_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_wstrb  (d_wstrb),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata),
        .ram_en   (ram_en),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_wdata(ram_wdata),
        .ram_wstrb(ram_wstrb),
        .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // Single-port synchronous RAM, one-cycle read latency, byte write enables.
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (ram_wstrb[b]) mem[ram_addr[9:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
                end
            end else begin
                ram_rdata <= mem[ram_addr[9:2]];
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    logic exp_i, exp_d, prev_i, prev_d;

    initial begin
        for (int k = 0; k < 256; k++) mem[k] = '0;
        mem[8'h10] = 32'h0050_0093;   // 0x40
        mem[8'h20] = 32'h1111_1111;   // 0x80
        mem[8'h80] = 32'h2222_2222;   // 0x200
        ram_rdata = '0;

        reset   = 1'b1;
        i_req   = 1'b1;               // request during reset must not be granted
        i_addr  = 32'h40;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = '0;
        d_wdata = '0;
        d_wstrb = '0;

        // Reset state
        @(negedge clk); #1;
        check("rst_i_gnt", i_gnt, 0);
        check("rst_ram_en", ram_en, 0);
        check("rst_i_rvalid", i_rvalid, 0);
        check("rst_d_rvalid", d_rvalid, 0);
        @(negedge clk);
        reset = 1'b0;
        i_req = 1'b0;
        #1;
        check("idle_ram_addr", ram_addr, 0);

        // Single fetch
        @(negedge clk);
        i_req = 1'b1; i_addr = 32'h40;
        #1;
        check("f_i_gnt", i_gnt, 1);
        check("f_d_gnt", d_gnt, 0);
        check("f_ram_en", ram_en, 1);
        check("f_ram_we", ram_we, 0);
        check("f_ram_addr", ram_addr, 32'h40);
        @(negedge clk);
        i_req = 1'b0;
        #1;
        check("f_i_rvalid", i_rvalid, 1);
        check("f_i_rdata", i_rdata, 32'h0050_0093);
        check("f_d_rvalid", d_rvalid, 0);
        @(negedge clk); #1;
        check("f_i_rvalid_end", i_rvalid, 0);

        // Data write with partial strobe
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'b0011;
        #1;
        check("w_d_gnt", d_gnt, 1);
        check("w_ram_we", ram_we, 1);
        check("w_ram_wstrb", ram_wstrb, 4'b0011);
        check("w_ram_wdata", ram_wdata, 32'hDEAD_BEEF);
        check("w_ram_addr", ram_addr, 32'h100);
        @(negedge clk);
        d_req = 1'b0; d_we = 1'b0;
        #1;
        check("w_d_rvalid", d_rvalid, 1);
        check("w_i_rvalid", i_rvalid, 0);

        // Read-back; stale d_wstrb must not reach the RAM on a read
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
        #1;
        check("r_d_gnt", d_gnt, 1);
        check("r_ram_we", ram_we, 0);
        check("r_ram_wstrb", ram_wstrb, 0);
        @(negedge clk);
        d_req = 1'b0;
        #1;
        check("r_d_rvalid", d_rvalid, 1);
        check("r_d_rdata", d_rdata, 32'h0000_BEEF);

        // Conflict: both held high for 20 cycles
        @(negedge clk);
        i_req = 1'b1; i_addr = 32'h40;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
        prev_i = 1'b0; prev_d = 1'b0;
        for (int c = 0; c < 20; c++) begin
`ifdef MEM_ARB_RR_EN
            exp_i = (c % 2 == 0);
`else
            exp_i = (c == 8 || c == 17);
`endif
            exp_d = ~exp_i;
            #1;
            check($sformatf("c%0d_i_gnt", c), i_gnt, exp_i);
            check($sformatf("c%0d_d_gnt", c), d_gnt, exp_d);
            check($sformatf("c%0d_i_rvalid", c), i_rvalid, prev_i);
            check($sformatf("c%0d_d_rvalid", c), d_rvalid, prev_d);
            prev_i = exp_i;
            prev_d = exp_d;
            @(negedge clk);
        end
        i_req = 1'b0; d_req = 1'b0;
        #1;
        check("c_tail_i_rvalid", i_rvalid, prev_i);
        check("c_tail_d_rvalid", d_rvalid, prev_d);

        // Back-to-back: fetch at N, data read at N+1
        @(negedge clk);
        i_req = 1'b1; i_addr = 32'h80;
        #1;
        check("b_i_gnt", i_gnt, 1);
        @(negedge clk);
        i_req = 1'b0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
        #1;
        check("b_d_gnt", d_gnt, 1);
        check("b_i_rvalid", i_rvalid, 1);
        check("b_i_rdata", i_rdata, 32'h1111_1111);
        check("b_d_rvalid_early", d_rvalid, 0);
        @(negedge clk);
        d_req = 1'b0;
        #1;
        check("b_d_rvalid", d_rvalid, 1);
        check("b_d_rdata", d_rdata, 32'h2222_2222);
        check("b_i_rvalid_end", i_rvalid, 0);

        // Reset mid-read: fetch granted at N, reset asserted in N+1
        @(negedge clk);
        i_req = 1'b1; i_addr = 32'h40;
        #1;
        check("m_i_gnt", i_gnt, 1);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check("m_i_rvalid", i_rvalid, 0);
        check("m_i_gnt_rst", i_gnt, 0);
        check("m_ram_en", ram_en, 0);
        @(negedge clk);
        reset = 1'b0;
        i_req = 1'b0;
        #1;
        check("m_i_rvalid_rel", i_rvalid, 0);
        check("m_d_rvalid_rel", d_rvalid, 0);
        @(negedge clk);
        i_req = 1'b1; i_addr = 32'h40;
        #1;
        check("m2_i_gnt", i_gnt, 1);
        @(negedge clk);
        i_req = 1'b0;
        #1;
        check("m2_i_rvalid", i_rvalid, 1);
        check("m2_i_rdata", i_rdata, 32'h0050_0093);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

- Shares one single-port synchronous RAM between two requesters of the multi-cycle core:
  - the instruction-fetch port (read-only);
  - the load/store data port (read/write).
- Sits between the core and the unified RAM, so fetch and data no longer need separate memories.
- Arbitrates every cycle, tracks which requester owns the one-cycle-latency read return, and contains a starvation guard so fetch cannot be locked out by back-to-back data traffic.

## Interface
Parameters:
- ADDR_W, 32, address width of both requesters and the RAM.
- DATA_W, 32, data width; must be a multiple of 8.
- STARVE_LIMIT, 8, consecutive denied fetch cycles before fetch is forced to win; must be ≥ 1.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
  - clk  in  1  clock.
  - reset  in  1  asynchronous, active-high reset.
- Instruction-fetch port:
  - i_req  in  1  fetch request; held with i_addr stable until i_gnt.
  - i_addr  in  ADDR_W  fetch byte address.
  - i_gnt  out  1  fetch request accepted this cycle.
  - i_rvalid  out  1  fetch read data valid.
  - i_rdata  out  DATA_W  fetch read data.
- Data port:
  - d_req  in  1  data request; held with d_we, d_addr, d_wdata and d_wstrb stable until d_gnt.
  - d_we  in  1  1 = write, 0 = read.
  - d_addr  in  ADDR_W  data byte address.
  - d_wdata  in  DATA_W  write data.
  - d_wstrb  in  DATA_W/8  byte write enables.
  - d_gnt  out  1  data request accepted this cycle.
  - d_rvalid  out  1  data completion (read data valid, or write done).
  - d_rdata  out  DATA_W  data read data.
- RAM port:
  - ram_en  out  1  RAM access this cycle.
  - ram_we  out  1  RAM write.
  - ram_addr  out  ADDR_W  RAM address; the winner's address.
  - ram_wdata  out  DATA_W  RAM write data.
  - ram_wstrb  out  DATA_W/8  RAM byte enables; all zero on reads.
  - ram_rdata  in  DATA_W  RAM read data; valid one cycle after a read with ram_en.

## Operation
- Arbitration is combinational from i_req, d_req and the registered starvation state. At most one of i_gnt and d_gnt is high per cycle.
- Grant rules:
  - Only one requester asserts req: it is granted.
  - Both assert req (fixed priority): data wins, unless starve_hit = 1, in which case fetch wins.
- RAM outputs:
  - ram_en = i_gnt | d_gnt.
  - ram_we = d_gnt & d_we.
  - ram_addr, ram_wdata and ram_wstrb are taken from the winner.
  - When idle, ram_addr, ram_wdata and ram_wstrb are 0.
- Return tracking: a 2-bit registered owner, with states NONE, INSTR and DATA.
  - It is updated every cycle to reflect what was granted that cycle.
  - A data write is tracked as DATA, so that its completion pulse issues.
  - Transitions are any-to-any, every cycle.
- Completion outputs:
  - i_rvalid = (owner == INSTR).
  - d_rvalid = (owner == DATA).
  - i_rdata = d_rdata = ram_rdata, passed through.
- Starvation counter wait_cnt, width $clog2(STARVE_LIMIT+1):
  - increments, saturating, in each cycle with i_req & ~i_gnt;
  - clears to 0 in any cycle with i_gnt, or with ~i_req;
  - starve_hit = (wait_cnt == STARVE_LIMIT).
- Pipelining: a new grant may issue in the same cycle that an earlier grant's rvalid is high. Full throughput is one access per cycle.

## Timing
- Grant latency: 0 cycles (req high in cycle N gives gnt in cycle N).
- Completion: rvalid is high exactly in cycle N+1 for a grant in cycle N; rdata is valid in that same cycle.
- Simultaneous requests: one winner; the loser keeps req high and is granted no earlier than N+1.
- Fetch fairness: with d_req held high permanently and fixed priority, fetch is granted on the (STARVE_LIMIT+1)-th cycle after i_req rises.
- Reset, applied asynchronously including mid-operation:
  - owner = NONE, wait_cnt = 0, last_win = DATA;
  - i_rvalid = 0 and d_rvalid = 0 immediately;
  - i_gnt, d_gnt, ram_en and ram_we are forced to 0 while reset is high;
  - a read in flight when reset asserts produces no rvalid.
- Requirement on requesters: a requester must not drop req before gnt. Behaviour if it does is undefined. No checking is performed.

## Configuration
- MEM_ARB_RR_EN:
  - When defined: the both-request rule becomes round-robin.
    - A registered last_win bit records the most recent conflict winner.
    - The other requester wins the next conflict.
    - last_win updates only in cycles where both request.
    - Reset value is DATA, so the first conflict goes to fetch.
    - The starvation counter is still built but cannot reach its limit.
  - When undefined: fixed data priority with the starvation guard; last_win is not present.

## Test plan
- Single fetch: i_req=1, i_addr=0x40, RAM word 0x40 = 0x00500093.
  - Cycle N: i_gnt=1, ram_en=1, ram_we=0.
  - Cycle N+1: i_rvalid=1, i_rdata=0x00500093; d_rvalid stays 0.
- Data write then read:
  - Write d_addr=0x100, d_wdata=0xDEADBEEF, d_wstrb=4'b0011.
    - Cycle N: d_gnt=1, ram_we=1, ram_wstrb=0011.
    - Cycle N+1: d_rvalid=1.
  - Read-back of 0x100 returns 0x0000BEEF, given RAM pre-cleared to 0.
- Conflict, fixed priority, STARVE_LIMIT=8: i_req and d_req both held high for 20 cycles.
  - d_gnt for cycles 0–7, i_gnt at cycle 8, d_gnt again at cycle 9.
  - Each i_rvalid/d_rvalid follows its grant by exactly 1 cycle.
- Conflict with MEM_ARB_RR_EN: both requesters held high.
  - i_gnt on cycle 0, d_gnt on cycle 1, alternating thereafter.
- Back-to-back: fetch granted at N, data read granted at N+1.
  - i_rvalid at N+1 and d_rvalid at N+2, each carrying correct distinct data.
- Reset mid-read: reset asserted in cycle N+1 after a read grant at N.
  - i_rvalid=0, i_gnt=0, ram_en=0 immediately.
  - After release, the next fetch completes normally with owner starting at NONE.
